// File: rtl/uart_csr_bank_pkg.sv
// Register map, interrupt bit positions and read-mux types shared by the
// multi-channel UART CSR bank and its per-channel register slices.
package uart_csr_bank_pkg;

  localparam logic [2:0] REG_BAUD     = 3'd0;
  localparam logic [2:0] REG_CTRL     = 3'd1;
  localparam logic [2:0] REG_STATUS   = 3'd2;
  localparam logic [2:0] REG_INT_EN   = 3'd3;
  localparam logic [2:0] REG_INT_STAT = 3'd4;
  localparam logic [2:0] REG_CLR      = 3'd5;

  localparam int unsigned INT_PAR    = 0;
  localparam int unsigned INT_TXDONE = 1;
  localparam int unsigned INT_FREE   = 2;

  typedef logic [2:0] uart_int_t;

  typedef struct packed {
    logic parity_sticky;
    logic free;
    logic busy;
  } uart_status_t;

  // Indices 6 and 7 are reserved and answer with an error response.
  function automatic logic reg_is_valid(input logic [2:0] idx);
    return (idx <= REG_CLR);
  endfunction

endpackage

// File: rtl/uart_csr_chan.sv
// One UART channel's register slice: baud/ctrl/int-enable registers, edge
// detectors, parity sticky bit, write-1-to-clear status and the irq flop.
module uart_csr_chan
  import uart_csr_bank_pkg::*;
#(
  parameter int                BAUD_W   = 16,
  parameter logic [BAUD_W-1:0] BAUD_RST = 16'd434,
  parameter int                DATA_W   = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_wr_en,
  input  logic [2:0]        i_reg,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_parity_error,
  input  logic              i_busy,
  input  logic              i_free,
  output logic [BAUD_W-1:0] o_baud,
  output logic [7:0]        o_ctrl,
  output uart_int_t         o_int_en,
  output uart_int_t         o_int_stat,
  output logic              o_sticky,
  output logic              o_irq
);

  logic [BAUD_W-1:0] r_baud;
  logic [7:0]        r_ctrl;
  uart_int_t         r_int_en;
  uart_int_t         r_int_stat;
  logic              r_sticky;
  logic              r_irq;
  logic              r_busy_q;
  logic              r_free_q;
  logic              r_par_q;

  logic      w_sel_baud;
  logic      w_sel_ctrl;
  logic      w_sel_en;
  logic      w_sel_stat;
  logic      w_sel_clr;
  uart_int_t w_event;
  uart_int_t w_w1c;
  logic      w_clr;
  logic      w_unused_wdata;

  always_comb begin
    w_sel_baud = 1'b0;
    w_sel_ctrl = 1'b0;
    w_sel_en   = 1'b0;
    w_sel_stat = 1'b0;
    w_sel_clr  = 1'b0;
    case (i_reg)
      REG_BAUD:     w_sel_baud = i_wr_en;
      REG_CTRL:     w_sel_ctrl = i_wr_en;
      REG_INT_EN:   w_sel_en   = i_wr_en;
      REG_INT_STAT: w_sel_stat = i_wr_en;
      REG_CLR:      w_sel_clr  = i_wr_en;
      default:      w_sel_clr  = 1'b0;
    endcase
  end

  always_comb begin
    w_event             = '0;
    w_event[INT_PAR]    = i_parity_error & ~r_par_q;
    w_event[INT_TXDONE] = ~i_busy & r_busy_q;
    w_event[INT_FREE]   = i_free & ~r_free_q;
  end

  assign w_w1c          = w_sel_stat ? uart_int_t'(i_wdata[2:0]) : 3'b000;
  assign w_clr          = w_sel_clr & i_wdata[0];
  assign w_unused_wdata = ^i_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_q <= 1'b0;
      r_free_q <= 1'b1;
      r_par_q  <= 1'b0;
    end else begin
      r_busy_q <= i_busy;
      r_free_q <= i_free;
      r_par_q  <= i_parity_error;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_baud   <= BAUD_RST;
      r_ctrl   <= 8'h00;
      r_int_en <= 3'b000;
    end else begin
      if (w_sel_baud) r_baud   <= i_wdata[BAUD_W-1:0];
      if (w_sel_ctrl) r_ctrl   <= i_wdata[7:0];
      if (w_sel_en)   r_int_en <= uart_int_t'(i_wdata[2:0]);
    end
  end

  // Events are ORed in after the clear so a coincident hardware set wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_int_stat <= 3'b000;
      r_sticky   <= 1'b0;
      r_irq      <= 1'b0;
    end else begin
      r_int_stat <= (r_int_stat & ~w_w1c) | w_event;
      r_sticky   <= (r_sticky & ~w_clr) | w_event[INT_PAR];
      r_irq      <= |(r_int_stat & r_int_en);
    end
  end

  assign o_baud     = r_baud;
  assign o_ctrl     = r_ctrl;
  assign o_int_en   = r_int_en;
  assign o_int_stat = r_int_stat;
  assign o_sticky   = r_sticky;
  assign o_irq      = r_irq;

endmodule

// File: rtl/uart_csr_bank.sv
// Register-bus front end for N_CH UART channels: address decode, read mux
// and a single-entry response register with valid/ready backpressure.
module uart_csr_bank
  import uart_csr_bank_pkg::*;
#(
  parameter int                N_CH     = 4,
  parameter int                BAUD_W   = 16,
  parameter logic [BAUD_W-1:0] BAUD_RST = 16'd434,
  parameter int                DATA_W   = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_write,
  input  logic [5:0]             req_addr,
  input  logic [DATA_W-1:0]      req_wdata,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [DATA_W-1:0]      rsp_rdata,
  output logic                   rsp_err,
  output logic [N_CH*BAUD_W-1:0] baud_rate,
  output logic [N_CH*8-1:0]      ctrl,
  input  logic [N_CH-1:0]        parity_error,
  input  logic [N_CH-1:0]        busy,
  input  logic [N_CH-1:0]        free,
  output logic [N_CH-1:0]        irq
);

  logic              r_rsp_valid;
  logic              r_rsp_err;
  logic [DATA_W-1:0] r_rsp_rdata;

  logic [2:0]        w_ch;
  logic [2:0]        w_reg;
  logic              w_ch_bad;
  logic              w_err;
  logic              w_req_ready;
  logic              w_accept;
  logic [N_CH-1:0]   w_wr_en;
  uart_int_t         w_int_en   [N_CH];
  uart_int_t         w_int_stat [N_CH];
  logic [N_CH-1:0]   w_sticky;

  logic [BAUD_W-1:0] w_sel_baud;
  logic [7:0]        w_sel_ctrl;
  uart_int_t         w_sel_en;
  uart_int_t         w_sel_ist;
  logic              w_sel_busy;
  logic              w_sel_free;
  logic              w_sel_sticky;
  uart_status_t      w_status;
  logic [DATA_W-1:0] w_rd_data;

  assign w_ch        = req_addr[5:3];
  assign w_reg       = req_addr[2:0];
  assign w_ch_bad    = ({1'b0, w_ch} >= 4'(N_CH));
  assign w_err       = w_ch_bad | ~reg_is_valid(w_reg);
  assign w_req_ready = ~r_rsp_valid | rsp_ready;
  assign w_accept    = req_valid & w_req_ready;

  always_comb begin
    w_wr_en = '0;
    for (int c = 0; c < N_CH; c++) begin
      w_wr_en[c] = w_accept & req_write & ~w_err & (w_ch == 3'(c));
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_chan
    uart_csr_chan #(
      .BAUD_W   (BAUD_W),
      .BAUD_RST (BAUD_RST),
      .DATA_W   (DATA_W)
    ) u_chan (
      .clk            (clk),
      .rst_n          (rst_n),
      .i_wr_en        (w_wr_en[g]),
      .i_reg          (w_reg),
      .i_wdata        (req_wdata),
      .i_parity_error (parity_error[g]),
      .i_busy         (busy[g]),
      .i_free         (free[g]),
      .o_baud         (baud_rate[g*BAUD_W +: BAUD_W]),
      .o_ctrl         (ctrl[g*8 +: 8]),
      .o_int_en       (w_int_en[g]),
      .o_int_stat     (w_int_stat[g]),
      .o_sticky       (w_sticky[g]),
      .o_irq          (irq[g])
    );
  end

  // Channel select is one-hot over the loop, so OR-accumulation acts as a mux.
  always_comb begin
    w_sel_baud   = '0;
    w_sel_ctrl   = 8'h00;
    w_sel_en     = 3'b000;
    w_sel_ist    = 3'b000;
    w_sel_busy   = 1'b0;
    w_sel_free   = 1'b0;
    w_sel_sticky = 1'b0;
    for (int c = 0; c < N_CH; c++) begin
      w_sel_baud   = w_sel_baud   | ((w_ch == 3'(c)) ? baud_rate[c*BAUD_W +: BAUD_W] : '0);
      w_sel_ctrl   = w_sel_ctrl   | ((w_ch == 3'(c)) ? ctrl[c*8 +: 8] : 8'h00);
      w_sel_en     = w_sel_en     | ((w_ch == 3'(c)) ? w_int_en[c] : 3'b000);
      w_sel_ist    = w_sel_ist    | ((w_ch == 3'(c)) ? w_int_stat[c] : 3'b000);
      w_sel_busy   = w_sel_busy   | ((w_ch == 3'(c)) & busy[c]);
      w_sel_free   = w_sel_free   | ((w_ch == 3'(c)) & free[c]);
      w_sel_sticky = w_sel_sticky | ((w_ch == 3'(c)) & w_sticky[c]);
    end
  end

  assign w_status = '{parity_sticky: w_sel_sticky, free: w_sel_free, busy: w_sel_busy};

  always_comb begin
    w_rd_data = '0;
    case (w_reg)
      REG_BAUD:     w_rd_data[BAUD_W-1:0] = w_sel_baud;
      REG_CTRL:     w_rd_data[7:0]        = w_sel_ctrl;
      REG_STATUS:   w_rd_data[2:0]        = w_status;
      REG_INT_EN:   w_rd_data[2:0]        = w_sel_en;
      REG_INT_STAT: w_rd_data[2:0]        = w_sel_ist;
      default:      w_rd_data             = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end else if (w_accept) begin
      r_rsp_valid <= 1'b1;
      r_rsp_err   <= w_err;
      r_rsp_rdata <= (req_write | w_err) ? '0 : w_rd_data;
    end else if (rsp_ready) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_rdata <= '0;
    end
  end

  assign req_ready = w_req_ready;
  assign rsp_valid = r_rsp_valid;
  assign rsp_err   = r_rsp_err;
  assign rsp_rdata = r_rsp_rdata;

endmodule
